// File: rtl/core_pkg.sv
// Shared definitions for the core front end.
// Provides the fetch FSM state encoding, the NOP bubble instruction and the
// default reset PC used by the fetch stage.
package core_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous, active-low
//   load     - load pc from target (takes priority over incr)
//   target   - redirect target, low bits passed unchanged
//   incr     - advance pc by 4 (wraps modulo 2^32)
//   pc       - current program counter
//   pc_plus4 - pc + 4, modulo 2^32
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] target,
  input  logic        incr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= target;
    end else if (incr) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory, buffers the returned word and presents it to
// the decode register (NOP bubble when nothing is ready).
// Ports:
//   clk, reset            - clock; synchronous active-low reset
//   StallF                - decode register not loading; hold presented instr
//   PCSrcE, PCTargetE     - redirect request and target from execute
//   imem_req, imem_addr   - request valid and word address (= pc)
//   imem_gnt              - memory accepts the request this cycle
//   imem_rvalid, imem_rdata - response valid and instruction word
//   InstrF, PCF, PCPlus4F, ValidF - outputs to the decode register
//   state_dbg             - current fetch FSM state (fetch_state_e encoding)
//
// Handshake: a request transfers on a cycle where imem_req=1 and
// imem_gnt=1; exactly one response (imem_rvalid=1) follows in a later cycle.
// imem_req/imem_addr come only from registered state, so they never depend
// on imem_gnt. imem_rvalid outside WAIT is ignored.
module ifetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF,
  output logic [1:0]  state_dbg
);

  fetch_state_e state;
  logic         drop;
  logic [31:0]  instr_buf;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         pc_incr;

  // A redirect always retargets the PC, whatever the state: in REQ it
  // changes the (still ungranted or just-granted) address, in WAIT it marks
  // the in-flight response stale, in HOLD it discards the buffer.
  assign pc_incr = (state == FETCH_HOLD) && !StallF && !PCSrcE;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (PCSrcE),
    .target  (PCTargetE),
    .incr    (pc_incr),
    .pc      (pc),
    .pc_plus4(pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH_REQ;
      drop      <= 1'b0;
      instr_buf <= NOP;
    end else begin
      unique case (state)
        FETCH_REQ: begin
          if (imem_gnt) begin
            state <= FETCH_WAIT;
            // Grant belongs to the old address if a redirect lands with it.
            drop  <= PCSrcE;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (drop || PCSrcE) begin
              state <= FETCH_REQ;
            end else begin
              instr_buf <= imem_rdata;
              state     <= FETCH_HOLD;
            end
          end else if (PCSrcE) begin
            drop <= 1'b1;
          end
        end
        FETCH_HOLD: begin
          if (PCSrcE || !StallF) begin
            state <= FETCH_REQ;
          end
        end
        default: begin
          state <= FETCH_REQ;
          drop  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = (state == FETCH_REQ);
  assign imem_addr = pc;
  assign ValidF    = (state == FETCH_HOLD);
  assign InstrF    = ValidF ? instr_buf : NOP;
  assign PCF       = pc;
  assign PCPlus4F  = pc_plus4;
  assign state_dbg = state;

endmodule
